// File: rtl/rx_window_sched.sv
// Round-robin RX window scheduler: warm-up, active window, cool-down on one shared receive path.
// Optional post-window guard interval is built when RXSCHED_GUARD_EN is defined.
module rx_window_sched #(
    parameter int NREQ       = 4,
    parameter int LEN_W      = 8,
    parameter int WARMUP_CYC = 4,
    parameter int GUARD_CYC  = 2
) (
    input  logic                    ck,
    input  logic                    arst,
    input  logic                    isolateM1M3,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    aborted,
    output logic                    rx_warm,
    output logic                    radioRxEn
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int WU_W  = $clog2(WARMUP_CYC + 1);
    localparam int GD_W  = $clog2(GUARD_CYC + 1);
    localparam int CNT_A = (LEN_W > WU_W) ? LEN_W : WU_W;
    localparam int CNT_W = (CNT_A > GD_W) ? CNT_A : GD_W;

`ifdef RXSCHED_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WARMUP   = 3'd1,
        S_ACTIVE   = 3'd2,
        S_COOLDOWN = 3'd3,
        S_GUARD    = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_ptr;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic               r_aborted;
    logic               r_rx_warm;
    logic               r_rx_en;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_abort;
    logic [2*NREQ-1:0]  w_rot;
    logic               w_found;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W:0]     w_adv;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_adv;
    logic [LEN_W-1:0]   w_win_len;
    logic [NREQ-1:0]    w_owner_oh;

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign rx_warm   = r_rx_warm;
    assign radioRxEn = r_rx_en;

    // Round-robin pick: rotate requests so the pointer lands at bit 0, take the first set bit.
    always_comb begin
        w_rot     = {req, req} >> r_ptr;
        w_found   = 1'b0;
        w_sum     = '0;
        w_win     = '0;
        w_win_len = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (PTR_W+1)'(k);
                w_win   = (w_sum >= (PTR_W+1)'(NREQ)) ? PTR_W'(w_sum - (PTR_W+1)'(NREQ))
                                                      : PTR_W'(w_sum);
            end else begin
                w_found = w_found;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_win_len = req_len[i*LEN_W +: LEN_W];
            end else begin
                w_win_len = w_win_len;
            end
        end
        w_adv     = {1'b0, w_win} + (PTR_W+1)'(1);
        w_ptr_adv = (w_adv == (PTR_W+1)'(NREQ)) ? '0 : PTR_W'(w_adv);
    end

    // Next-state sequencing of the window phases, including isolation abort.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !isolateM1M3) begin
                    w_state_nxt = S_WARMUP;
                    w_cnt_nxt   = CNT_W'(WARMUP_CYC - 1);
                    w_len_nxt   = w_win_len;
                    w_owner_nxt = w_win;
                    w_ptr_nxt   = w_ptr_adv;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WARMUP: begin
                if (isolateM1M3) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (r_cnt == '0) begin
                    if (r_len != '0) begin
                        w_state_nxt = S_ACTIVE;
                        w_cnt_nxt   = CNT_W'(r_len) - CNT_W'(1);
                    end else begin
                        w_state_nxt = S_COOLDOWN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (isolateM1M3) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_COOLDOWN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_COOLDOWN: begin
                if (GUARD_ON && (GUARD_CYC > 0)) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = CNT_W'(GUARD_CYC - 1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GUARD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot decode of the owner that will hold the path next cycle.
    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (w_owner_nxt == PTR_W'(i));
        end
    end

    // State, datapath and registered outputs; outputs decode the upcoming state.
    always_ff @(posedge ck) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_aborted <= 1'b0;
            r_rx_warm <= 1'b0;
            r_rx_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= ((w_state_nxt == S_WARMUP) || (w_state_nxt == S_ACTIVE) ||
                          (w_state_nxt == S_COOLDOWN)) ? w_owner_oh : '0;
            r_done    <= (w_state_nxt == S_COOLDOWN) ? w_owner_oh : '0;
            r_aborted <= w_abort;
            r_rx_warm <= (w_state_nxt == S_WARMUP) || (w_state_nxt == S_ACTIVE);
            r_rx_en   <= (w_state_nxt == S_ACTIVE);
        end
    end

endmodule

// File: tb/tb_rx_window_sched.sv
// Randomized bench for rx_window_sched against a timeline model of each window
// (grant cycle + warm-up + length + cool-down [+ guard]).
module tb_rx_window_sched;

    localparam int NREQ  = 4;
    localparam int LEN_W = 8;
    localparam int WU    = 4;
    localparam int GC    = 2;
`ifdef RXSCHED_GUARD_EN
    localparam int GE = GC;
`else
    localparam int GE = 0;
`endif
    localparam int NCYC = 4000;

    logic                  ck = 1'b0;
    logic                  arst;
    logic                  isolateM1M3;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  aborted;
    logic                  rx_warm;
    logic                  radioRxEn;

    always #5 ck = ~ck;

    rx_window_sched #(
        .NREQ(NREQ), .LEN_W(LEN_W), .WARMUP_CYC(WU), .GUARD_CYC(GC)
    ) dut (
        .ck(ck), .arst(arst), .isolateM1M3(isolateM1M3),
        .req(req), .req_len(req_len),
        .gnt(gnt), .done(done), .aborted(aborted),
        .rx_warm(rx_warm), .radioRxEn(radioRxEn)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // model: one window described by grant cycle, owner and length
    bit              m_valid;
    int              m_g, m_L, m_owner, m_ptr, m_free, idx, e, iso_left;
    bit              found;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_ab, e_warm, e_en;

    initial begin
        arst = 1'b1; isolateM1M3 = 1'b0; req = '0; req_len = '0;
        m_valid = 1'b0; m_ptr = 0; m_free = 0; m_g = 0; m_L = 0; m_owner = 0;
        iso_left = 0;
        e_gnt = '0; e_done = '0; e_ab = 1'b0; e_warm = 1'b0; e_en = 1'b0;
        repeat (3) @(posedge ck);

        for (int n = 0; n < NCYC; n++) begin
            cyc = n;
            @(negedge ck);
            check_eq("gnt",       32'(gnt),       32'(e_gnt));
            check_eq("done",      32'(done),      32'(e_done));
            check_eq("aborted",   32'(aborted),   32'(e_ab));
            check_eq("rx_warm",   32'(rx_warm),   32'(e_warm));
            check_eq("radioRxEn", 32'(radioRxEn), 32'(e_en));

            // stimulus for this cycle: rotation warm-up, then random, then isolation/reset
            for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 6));
            if (n < 80) begin
                req = 4'b1011; isolateM1M3 = 1'b0; arst = 1'b0;
            end else begin
                if ($urandom_range(0, 9) < 3) req = NREQ'($urandom);
                if (n < 500) begin
                    isolateM1M3 = 1'b0; arst = 1'b0;
                end else begin
                    if (iso_left > 0) begin
                        isolateM1M3 = 1'b1; iso_left--;
                    end else if ($urandom_range(0, 15) == 0) begin
                        isolateM1M3 = 1'b1; iso_left = $urandom_range(0, 5);
                    end else begin
                        isolateM1M3 = 1'b0;
                    end
                    arst = ($urandom_range(0, 99) == 0);
                end
            end

            // expected outputs for cycle n+1
            e_gnt = '0; e_done = '0; e_ab = 1'b0; e_warm = 1'b0; e_en = 1'b0;
            if (arst) begin
                m_valid = 1'b0; m_free = n + 1; m_ptr = 0;
            end else begin
                if (m_valid && n >= m_g && n < m_g + WU + m_L && isolateM1M3) begin
                    m_valid = 1'b0; m_free = n + 1; e_ab = 1'b1;
                end else if (n >= m_free && !isolateM1M3 && req != '0) begin
                    found = 1'b0;
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (m_ptr + k) % NREQ;
                        if (!found && req[idx]) begin
                            found = 1'b1; m_owner = idx;
                        end
                    end
                    m_L     = int'(req_len[m_owner*LEN_W +: LEN_W]);
                    m_g     = n + 1;
                    m_valid = 1'b1;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_free  = m_g + WU + m_L + 1 + GE;
                end
                if (m_valid) begin
                    e = n + 1 - m_g;
                    if (e >= 0 && e <= WU + m_L) e_gnt[m_owner] = 1'b1;
                    if (e == WU + m_L) e_done[m_owner] = 1'b1;
                    e_warm = (e >= 0 && e < WU + m_L);
                    e_en   = (e >= WU && e < WU + m_L);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
